// File: rtl/ax309_mem_ctl.sv
// Request/ack bus to ax309 single-port BRAM port sequencer (ISSUE/CAPT/ACK timing).
// Defining AX309_MEM_CLR_EN adds a post-reset sweep that writes FILL to every address.
module ax309_mem_ctl #(
  parameter int unsigned   AW   = 14,
  parameter int unsigned   DW   = 8,
  parameter logic [DW-1:0] FILL = '0
) (
  input  logic          clka,
  input  logic          rsta_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dina,
  output logic          wea,
  input  logic [DW-1:0] douta
);

`ifdef AX309_MEM_CLR_EN
  typedef enum logic [2:0] {StIdle, StIssue, StCapt, StAck, StClear, StDrain} state_e;
  localparam state_e      StReset = StClear;
  localparam logic [AW:0] CntOne  = (AW + 1)'(1);

  // Extra MSB marks that the last address has been issued.
  logic [AW:0] clr_cnt;
  logic [1:0]  drain_cnt;
`else
  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StAck} state_e;
  localparam state_e StReset = StIdle;

  logic unused_fill;
  assign unused_fill = ^FILL;
  assign busy        = 1'b0;
`endif

  state_e state;
  logic   is_rd;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state <= StReset;
      ack   <= 1'b0;
      rdata <= '0;
      addra <= '0;
      dina  <= '0;
      wea   <= 1'b0;
      is_rd <= 1'b0;
`ifdef AX309_MEM_CLR_EN
      busy      <= 1'b0;
      clr_cnt   <= '0;
      drain_cnt <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (req) begin
            addra <= addr;
            dina  <= wdata;
            wea   <= we;
            is_rd <= ~we;
            state <= StIssue;
          end
        end
        StIssue: begin
          // RAM has latched addra/wea on this edge; dina stays put for the commit.
          wea   <= 1'b0;
          state <= StCapt;
        end
        StCapt: begin
          if (is_rd) begin
            rdata <= douta;
          end
          ack   <= 1'b1;
          state <= StAck;
        end
        StAck: begin
          ack   <= 1'b0;
          state <= StIdle;
        end
`ifdef AX309_MEM_CLR_EN
        StClear: begin
          busy <= 1'b1;
          if (clr_cnt[AW]) begin
            wea   <= 1'b0;
            state <= StDrain;
          end else begin
            wea     <= 1'b1;
            dina    <= FILL;
            addra   <= clr_cnt[AW-1:0];
            clr_cnt <= clr_cnt + CntOne;
          end
        end
        StDrain: begin
          // Let the final latched write commit before accepting requests.
          if (drain_cnt == 2'd2) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
`endif
        default: begin
          ack   <= 1'b0;
          wea   <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ax309_mem_ctl.sv
// Scoreboard bench for ax309_mem_ctl with a behavioural registered-address BRAM model.
// Define AX309_MEM_CLR_EN to also exercise the post-reset clear sweep.
module tb_ax309_mem_ctl;
  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 8;
  localparam int unsigned Depth = 1 << AW;
  localparam logic [7:0]  Fill  = 8'hE7;
`ifdef AX309_MEM_CLR_EN
  localparam logic [7:0] MemInit    = 8'h5C;
  localparam logic [7:0] ShadowInit = Fill;
`else
  localparam logic [7:0] MemInit    = 8'h00;
  localparam logic [7:0] ShadowInit = 8'h00;
`endif

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          wea;
  logic [DW-1:0] douta;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit         rd;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sbq[$];

  logic [7:0]    shadow[Depth];
  logic [7:0]    mem[Depth];
  logic [AW-1:0] ram_a_q;
  logic          ram_we_q;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;
  logic [AW-1:0] last_addr;

  ax309_mem_ctl #(
    .AW  (AW),
    .DW  (DW),
    .FILL(Fill)
  ) dut (
    .clka  (clk),
    .rsta_n(rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata),
    .busy  (busy),
    .addra (addra),
    .dina  (dina),
    .wea   (wea),
    .douta (douta)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: address/we registered, write committed one edge later with current dina.
  initial begin
    ram_a_q  = '0;
    ram_we_q = 1'b0;
    for (int i = 0; i < Depth; i++) mem[i] = MemInit;
    forever begin
      @(posedge clk);
      if (ram_we_q) mem[ram_a_q] <= dina;
      if (pl_en) mem[pl_addr] <= pl_data;
      ram_a_q  <= addra;
      ram_we_q <= wea;
    end
  end
  assign douta = mem[ram_a_q];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] out_val(input int i);
    case (i)
      0:       return 32'(ack);
      1:       return 32'(rdata);
      2:       return 32'(busy);
      3:       return 32'(addra);
      4:       return 32'(dina);
      default: return 32'(wea);
    endcase
  endfunction

  function automatic string out_name(input int i);
    case (i)
      0:       return "ack";
      1:       return "rdata";
      2:       return "busy";
      3:       return "addra";
      4:       return "dina";
      default: return "wea";
    endcase
  endfunction

  task automatic fill_shadow();
    for (int i = 0; i < Depth; i++) shadow[i] = ShadowInit;
  endtask

  task automatic start_txn(input bit w, input logic [AW-1:0] a, input logic [7:0] d,
                           input int due_off);
    exp_t e;
    req       = 1'b1;
    we        = w;
    addr      = a;
    wdata     = d;
    last_addr = a;
    e.rd      = !w;
    e.data    = w ? d : shadow[a];
    e.due     = cyc + due_off;
    if (w) shadow[a] = d;
    sbq.push_back(e);
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (ack === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_clear(output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en     = 1'b1;
    pl_addr   = a;
    pl_data   = d;
    shadow[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    pl_en   = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    fill_shadow();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (out_val(i) !== 32'h0) begin
        bad++;
        $display("FAIL reset_%s: got=%0h required=0", out_name(i), out_val(i));
      end
    end
    rst_n = 1'b1;
`ifndef AX309_MEM_CLR_EN
    repeat (3) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || wea !== 1'b0 || ack !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_idle: busy=%b wea=%b ack=%b required all 0", busy, wea, ack);
      end
    end
`endif
  endtask

`ifdef AX309_MEM_CLR_EN
  task automatic test_clear();
    int   bc   = 0;
    bit   back = 1'b0;
    bit   ok;
    exp_t e;
    logic [AW-1:0] rd_addrs[3] = '{14'h1FFF, 14'h0000, 14'h3FFF};
    // Request held from the start of the sweep; must wait until busy drops.
    req   = 1'b1;
    we    = 1'b0;
    addr  = 14'h1FFF;
    wdata = '0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        bc++;
        if (ack === 1'b1) back = 1'b1;
      end else if (bc > 0) break;
    end
    total++;
    if (bc != int'(Depth + 3)) begin
      bad++;
      $display("FAIL clear_busy_len: got=%0d required=%0d", bc, Depth + 3);
    end
    total++;
    if (back) begin
      bad++;
      $display("FAIL clear_ack_during_busy: got=1 required=0");
    end
    sbq.delete();
    for (int i = 0; i < 3; i++) begin
      start_txn(1'b0, rd_addrs[i], 8'h00, (i == 0) ? 3 : 4);
      wait_ack(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL clear_rd_ack[%0d]: ack=0 required=1", i);
      end else begin
        e = sbq.pop_front();
        if (cyc !== e.due) begin
          bad++;
          $display("FAIL clear_rd_latency[%0d]: cycle=%0d required=%0d", i, cyc, e.due);
        end
        total++;
        if (rdata !== e.data) begin
          bad++;
          $display("FAIL clear_rd_data[%0d]: got=%02h required=%02h", i, rdata, e.data);
        end
      end
    end
    req = 1'b0;
  endtask
`endif

  task automatic test_write_read();
    bit   ok;
    exp_t e;
    sbq.delete();
    @(negedge clk);
    start_txn(1'b1, 14'h0123, 8'hA5, 3);
    @(negedge clk);
    total++;
    if (wea !== 1'b1) begin
      bad++;
      $display("FAIL wr_wea_high: got=%b required=1", wea);
    end
    @(negedge clk);
    total++;
    if (wea !== 1'b0) begin
      bad++;
      $display("FAIL wr_wea_single: got=%b required=0", wea);
    end
    wait_ack(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wr_ack: ack=0 required=1");
    end else begin
      e = sbq.pop_front();
      if (cyc !== e.due) begin
        bad++;
        $display("FAIL wr_latency: cycle=%0d required=%0d", cyc, e.due);
      end
    end
    start_txn(1'b0, 14'h0123, 8'h00, 4);
    wait_ack(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rd_ack: ack=0 required=1");
    end else begin
      e = sbq.pop_front();
      if (cyc !== e.due) begin
        bad++;
        $display("FAIL rd_latency: cycle=%0d required=%0d", cyc, e.due);
      end
      total++;
      if (rdata !== e.data) begin
        bad++;
        $display("FAIL rd_data: got=%02h required=%02h", rdata, e.data);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ad[3] = '{14'h0000, 14'h3FFF, 14'h1000};
    logic [7:0]    dv[3] = '{8'h11, 8'h22, 8'h33};
    bit   ok;
    exp_t e;
    for (int i = 0; i < 3; i++) preload(ad[i], dv[i]);
    sbq.delete();
    for (int i = 0; i < 3; i++) begin
      start_txn(1'b0, ad[i], 8'h00, (i == 0) ? 3 : 4);
      wait_ack(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL b2b_ack[%0d]: ack=0 required=1", i);
      end else begin
        e = sbq.pop_front();
        if (cyc !== e.due) begin
          bad++;
          $display("FAIL b2b_spacing[%0d]: cycle=%0d required=%0d", i, cyc, e.due);
        end
        total++;
        if (rdata !== e.data) begin
          bad++;
          $display("FAIL b2b_data[%0d]: got=%02h required=%02h", i, rdata, e.data);
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic test_raw();
    bit   ok;
    exp_t e;
    preload(14'h2000, 8'hC3);
    sbq.delete();
    for (int i = 0; i < 2; i++) begin
      start_txn(i == 0, 14'h2000, 8'h5A, (i == 0) ? 3 : 4);
      wait_ack(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL raw_ack[%0d]: ack=0 required=1", i);
      end else begin
        e = sbq.pop_front();
        if (cyc !== e.due) begin
          bad++;
          $display("FAIL raw_latency[%0d]: cycle=%0d required=%0d", i, cyc, e.due);
        end
        if (e.rd) begin
          total++;
          if (rdata !== e.data) begin
            bad++;
            $display("FAIL raw_data: got=%02h required=%02h", rdata, e.data);
          end
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit   ok;
    exp_t e;
    sbq.delete();
    @(negedge clk);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 14'h0777;
    wdata = 8'h99;
    repeat (2) @(negedge clk);
    total++;
    if (addra !== 14'h0777 || dina !== 8'h99) begin
      bad++;
      $display("FAIL mid_pre_reset: addra=%h dina=%h required 0777/99", addra, dina);
    end
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (out_val(i) !== 32'h0) begin
        bad++;
        $display("FAIL mid_reset_%s: got=%0h required=0", out_name(i), out_val(i));
      end
    end
    @(negedge clk);
    total++;
    if (ack !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_hold_ack: got=%b required=0", ack);
    end
    rst_n = 1'b1;
`ifdef AX309_MEM_CLR_EN
    wait_clear(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL mid_reclear: busy did not complete a sweep");
    end
    fill_shadow();
`else
    @(negedge clk);
`endif
    for (int i = 0; i < 2; i++) begin
      start_txn(i == 0, 14'h3333, 8'h44, (i == 0) ? 3 : 4);
      wait_ack(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL mid_after_ack[%0d]: ack=0 required=1", i);
      end else begin
        e = sbq.pop_front();
        if (cyc !== e.due) begin
          bad++;
          $display("FAIL mid_after_latency[%0d]: cycle=%0d required=%0d", i, cyc, e.due);
        end
        if (e.rd) begin
          total++;
          if (rdata !== e.data) begin
            bad++;
            $display("FAIL mid_after_data: got=%02h required=%02h", rdata, e.data);
          end
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic test_idle();
    req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if (wea !== 1'b0 || ack !== 1'b0 || addra !== last_addr) begin
        bad++;
        $display("FAIL idle[%0d]: wea=%b ack=%b addra=%h required 0/0/%h", i, wea, ack, addra,
                 last_addr);
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef AX309_MEM_CLR_EN
    test_clear();
`endif
    test_write_read();
    test_back_to_back();
    test_raw();
    test_reset_mid();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
